// File: rtl/eth_rx_payload_buf.sv
// Receive payload buffer: filters MAC frames on destination MAC and EtherType, strips the
// 14-byte header and queues payloads in a circular byte RAM, exposed only once committed.
module eth_rx_payload_buf #(
    parameter int unsigned DEPTH_LOG2   = 11,
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic        i_rx_err,
    output logic [7:0]  o_rdata,
    output logic        o_rready,
    input  logic        i_rreq,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    hdr_cnt_q, hdr_cnt_d;
    logic          ucast_ok_q, ucast_ok_d, bcast_ok_q, bcast_ok_d, type_ok_q, type_ok_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
    logic [7:0]    rdata_q;
    logic [15:0]   frame_cnt_q, drop_cnt_q;
    logic [7:0]    mem [DEPTH];

    logic [3:0]    hdr_idx;
    logic [7:0]    hdr_exp;
    logic          ucast_ok_n, bcast_ok_n, type_ok_n, hdr_accept;
    logic [AW-1:0] wr_ptr_inc;
    logic          full, mem_we, rd_fire, frame_inc;
    logic [1:0]    drop_inc;
    logic [16:0]   drop_sum;

    assign o_rready    = (rd_ptr_q != commit_ptr_q);
    assign o_rdata     = rdata_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign rd_fire     = i_rreq && o_rready;
    assign wr_ptr_inc  = wr_ptr_q + AW'(1);
    assign full        = (wr_ptr_inc == rd_ptr_q);
    assign drop_sum    = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

    // A sof byte is always header byte 0, whatever state it interrupts.
    always_comb begin
        hdr_idx = (state_q == ST_HDR && !i_rx_sof) ? hdr_cnt_q : 4'd0;
        unique case (hdr_idx)
            4'd0:    hdr_exp = MAC_ADDR[47:40];
            4'd1:    hdr_exp = MAC_ADDR[39:32];
            4'd2:    hdr_exp = MAC_ADDR[31:24];
            4'd3:    hdr_exp = MAC_ADDR[23:16];
            4'd4:    hdr_exp = MAC_ADDR[15:8];
            4'd5:    hdr_exp = MAC_ADDR[7:0];
            4'd12:   hdr_exp = ETHERTYPE[15:8];
            4'd13:   hdr_exp = ETHERTYPE[7:0];
            default: hdr_exp = 8'h00;
        endcase
        ucast_ok_n = (i_rx_sof || ucast_ok_q) && (hdr_idx > 4'd5 || i_rx_data == hdr_exp);
        bcast_ok_n = (i_rx_sof || bcast_ok_q) && (hdr_idx > 4'd5 || i_rx_data == 8'hFF);
        type_ok_n  = (i_rx_sof || type_ok_q)  && (hdr_idx < 4'd12 || i_rx_data == hdr_exp);
        hdr_accept = type_ok_n && (ucast_ok_n || (ACCEPT_BCAST && bcast_ok_n));
    end

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        ucast_ok_d   = ucast_ok_q;
        bcast_ok_d   = bcast_ok_q;
        type_ok_d    = type_ok_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 2'd0;
        if (i_rx_valid) begin
            if (i_rx_sof) begin
                // DROP already counted its frame on entry.
                if (state_q == ST_HDR || state_q == ST_PAYLOAD) drop_inc = drop_inc + 2'd1;
                wr_ptr_d   = commit_ptr_q;
                hdr_cnt_d  = 4'd1;
                ucast_ok_d = ucast_ok_n;
                bcast_ok_d = bcast_ok_n;
                type_ok_d  = type_ok_n;
                if (i_rx_eof) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_HDR;
                end
            end else begin
                unique case (state_q)
                    ST_HDR: begin
                        hdr_cnt_d  = hdr_cnt_q + 4'd1;
                        ucast_ok_d = ucast_ok_n;
                        bcast_ok_d = bcast_ok_n;
                        type_ok_d  = type_ok_n;
                        if (i_rx_eof) begin
                            drop_inc = 2'd1;
                            state_d  = ST_IDLE;
                        end else if (hdr_cnt_q == 4'd13) begin
                            if (hdr_accept) begin
                                state_d = ST_PAYLOAD;
                            end else begin
                                drop_inc = 2'd1;
                                state_d  = ST_DROP;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (i_rx_eof && i_rx_err) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 2'd1;
                            state_d  = ST_IDLE;
                        end else if (full) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 2'd1;
                            state_d  = i_rx_eof ? ST_IDLE : ST_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_inc;
                            if (i_rx_eof) begin
                                commit_ptr_d = wr_ptr_inc;
                                frame_inc    = 1'b1;
                                state_d      = ST_IDLE;
                            end
                        end
                    end
                    ST_DROP: if (i_rx_eof) state_d = ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            hdr_cnt_q    <= 4'd0;
            ucast_ok_q   <= 1'b0;
            bcast_ok_q   <= 1'b0;
            type_ok_q    <= 1'b0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rdata_q      <= 8'h00;
            frame_cnt_q  <= 16'h0000;
            drop_cnt_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            ucast_ok_q   <= ucast_ok_d;
            bcast_ok_q   <= bcast_ok_d;
            type_ok_q    <= type_ok_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            if (rd_fire) begin
                rdata_q  <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (frame_inc && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // NOTE: the byte RAM has no reset; pointers alone define which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr_q] <= i_rx_data;
    end
endmodule

// File: tb/tb_eth_rx_payload_buf.sv
// Scoreboard bench for eth_rx_payload_buf: a default-depth instance and a 16-byte instance
// for overflow and wrap; accepted payload bytes are queued at send time and popped on reads.
module tb_eth_rx_payload_buf;
    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx_valid = '0, rx_sof = '0, rx_eof = '0, rx_err = '0, rreq = '0, rready;
    logic [7:0]  rx_data [2];
    logic [7:0]  rdata [2];
    logic [15:0] frame_cnt [2];
    logic [15:0] drop_cnt [2];

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic [7:0]  e0, e1;

    always #5 clk = ~clk;

    eth_rx_payload_buf dut0 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data[0]), .i_rx_valid(rx_valid[0]),
        .i_rx_sof(rx_sof[0]), .i_rx_eof(rx_eof[0]), .i_rx_err(rx_err[0]),
        .o_rdata(rdata[0]), .o_rready(rready[0]), .i_rreq(rreq[0]),
        .o_frame_cnt(frame_cnt[0]), .o_drop_cnt(drop_cnt[0])
    );

    eth_rx_payload_buf #(.DEPTH_LOG2(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data[1]), .i_rx_valid(rx_valid[1]),
        .i_rx_sof(rx_sof[1]), .i_rx_eof(rx_eof[1]), .i_rx_err(rx_err[1]),
        .o_rdata(rdata[1]), .o_rready(rready[1]), .i_rreq(rreq[1]),
        .o_frame_cnt(frame_cnt[1]), .o_drop_cnt(drop_cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a read accepted at edge N is compared after edge N+1.
    always @(negedge clk) begin
        if (pend0) begin
            if (exp_q0.size() == 0) check("rd0_unexpected_read", 32'(rdata[0]), 32'hFFFF_FFFF);
            else begin
                e0 = exp_q0.pop_front();
                check("rd0_data", 32'(rdata[0]), 32'(e0));
            end
        end
        pend0 = rreq[0] && rready[0] && !rst;
    end

    always @(negedge clk) begin
        if (pend1) begin
            if (exp_q1.size() == 0) check("rd1_unexpected_read", 32'(rdata[1]), 32'hFFFF_FFFF);
            else begin
                e1 = exp_q1.pop_front();
                check("rd1_data", 32'(rdata[1]), 32'(e1));
            end
        end
        pend1 = rreq[1] && rready[1] && !rst;
    end

    task automatic drive_byte(input int sel, input logic [7:0] d, input bit sof, input bit eof,
                              input bit err);
        @(posedge clk); #1;
        rx_valid[sel] = 1'b1;
        rx_data[sel]  = d;
        rx_sof[sel]   = sof;
        rx_eof[sel]   = eof;
        rx_err[sel]   = err;
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid[sel] = 1'b0;
            rx_sof[sel]   = 1'b0;
            rx_eof[sel]   = 1'b0;
            rx_err[sel]   = 1'b0;
        end
    endtask

    // len=0 puts eof on header byte 13; cut>0 stops after cut payload bytes with no eof.
    task automatic send_frame(input int sel, input logic [47:0] dst, input logic [15:0] et,
                              input int len, input logic [7:0] base, input bit err,
                              input int cut, input bit expect_ok);
        logic [7:0] b;
        int         n;
        for (int i = 0; i < 14; i++) begin
            if (i < 6)       b = dst[47-8*i -: 8];
            else if (i < 12) b = 8'hA0 + 8'(i);
            else if (i == 12) b = et[15:8];
            else             b = et[7:0];
            drive_byte(sel, b, i == 0, (i == 13) && (len == 0), 1'b0);
        end
        n = (cut > 0) ? cut : len;
        for (int p = 0; p < n; p++) begin
            b = base + 8'(p);
            drive_byte(sel, b, 1'b0, (cut == 0) && (p == len - 1), (cut == 0) && (p == len - 1) && err);
            if (expect_ok) begin
                if (sel == 0) exp_q0.push_back(b);
                else          exp_q1.push_back(b);
            end
        end
    endtask

    task automatic read_n(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rreq[sel] = 1'b1;
        end
        @(posedge clk); #1;
        rreq[sel] = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_err = '0; rreq = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    initial begin
        rx_data[0] = 8'h00;
        rx_data[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_rready0", 32'(rready[0]), 0);
        check("reset_rdata0", 32'(rdata[0]), 0);
        check("reset_frame0", 32'(frame_cnt[0]), 0);
        check("reset_drop0", 32'(drop_cnt[0]), 0);
        check("reset_rready1", 32'(rready[1]), 0);

        // Good frame, payload 01..0A.
        send_frame(0, MAC, ETYPE, 10, 8'h01, 1'b0, 0, 1'b1);
        check("good_rready_before", 32'(rready[0]), 0);
        idle(0, 1);
        check("good_rready_after_eof", 32'(rready[0]), 1);
        check("good_frame_cnt", 32'(frame_cnt[0]), 1);
        read_n(0, 10);
        check("good_rready_drained", 32'(rready[0]), 0);
        idle(0, 2);
        check("good_queue_empty", 32'(exp_q0.size()), 0);

        // Broadcast accepted; wrong dst, wrong type and runts dropped.
        do_reset();
        send_frame(0, BCAST, ETYPE, 4, 8'h20, 1'b0, 0, 1'b1);
        idle(0, 1);
        read_n(0, 4);
        idle(0, 2);
        check("bcast_frame_cnt", 32'(frame_cnt[0]), 1);
        send_frame(0, OTHER, ETYPE, 6, 8'h30, 1'b0, 0, 1'b0);
        idle(0, 2);
        check("bad_dst_drop", 32'(drop_cnt[0]), 1);
        check("bad_dst_rready", 32'(rready[0]), 0);
        send_frame(0, MAC, 16'h0800, 6, 8'h30, 1'b0, 0, 1'b0);
        drive_byte(0, 8'h02, 1'b1, 1'b1, 1'b0);
        idle(0, 1);
        send_frame(0, MAC, ETYPE, 0, 8'h00, 1'b0, 0, 1'b0);
        idle(0, 2);
        check("filter_runt_drops", 32'(drop_cnt[0]), 4);
        check("filter_frame_cnt", 32'(frame_cnt[0]), 1);
        check("filter_rready", 32'(rready[0]), 0);
        check("bcast_queue_empty", 32'(exp_q0.size()), 0);

        // Good, errored, good: only the good payloads come back, back-to-back.
        do_reset();
        send_frame(0, MAC, ETYPE, 3, 8'h30, 1'b0, 0, 1'b1);
        idle(0, 1);
        send_frame(0, MAC, ETYPE, 5, 8'h40, 1'b1, 0, 1'b0);
        idle(0, 1);
        send_frame(0, MAC, ETYPE, 4, 8'h50, 1'b0, 0, 1'b1);
        idle(0, 1);
        check("err_drop_cnt", 32'(drop_cnt[0]), 1);
        check("err_frame_cnt", 32'(frame_cnt[0]), 2);
        read_n(0, 7);
        check("err_rready_drained", 32'(rready[0]), 0);
        idle(0, 2);
        check("err_queue_empty", 32'(exp_q0.size()), 0);

        // 16-byte buffer: overflow, exact-capacity frame, then a wrapping frame.
        do_reset();
        send_frame(1, MAC, ETYPE, 20, 8'h01, 1'b0, 0, 1'b0);
        idle(1, 2);
        check("ovf_drop_cnt", 32'(drop_cnt[1]), 1);
        check("ovf_rready", 32'(rready[1]), 0);
        send_frame(1, MAC, ETYPE, 15, 8'h40, 1'b0, 0, 1'b1);
        idle(1, 1);
        check("cap_frame_cnt", 32'(frame_cnt[1]), 1);
        check("cap_rready", 32'(rready[1]), 1);
        read_n(1, 15);
        check("cap_rready_drained", 32'(rready[1]), 0);
        send_frame(1, MAC, ETYPE, 10, 8'h90, 1'b0, 0, 1'b1);
        idle(1, 1);
        read_n(1, 10);
        idle(1, 2);
        check("wrap_frame_cnt", 32'(frame_cnt[1]), 2);
        check("wrap_drop_cnt", 32'(drop_cnt[1]), 1);
        check("wrap_queue_empty", 32'(exp_q1.size()), 0);

        // sof mid-payload aborts the first frame; overread holds the last byte.
        do_reset();
        send_frame(0, MAC, ETYPE, 10, 8'h10, 1'b0, 5, 1'b0);
        send_frame(0, MAC, ETYPE, 6, 8'h60, 1'b0, 0, 1'b1);
        idle(0, 1);
        check("abort_drop_cnt", 32'(drop_cnt[0]), 1);
        check("abort_frame_cnt", 32'(frame_cnt[0]), 1);
        read_n(0, 9);
        idle(0, 2);
        check("overread_hold", 32'(rdata[0]), 32'h65);
        check("abort_queue_empty", 32'(exp_q0.size()), 0);

        // Reset mid-payload clears everything; the next frame still gets through.
        do_reset();
        send_frame(0, MAC, ETYPE, 3, 8'h70, 1'b0, 0, 1'b1);
        idle(0, 1);
        read_n(0, 1);
        idle(0, 2);
        check("pre_rst_rdata", 32'(rdata[0]), 32'h70);
        send_frame(0, MAC, ETYPE, 8, 8'hB0, 1'b0, 4, 1'b0);
        do_reset();
        check("rst_rready", 32'(rready[0]), 0);
        check("rst_rdata", 32'(rdata[0]), 0);
        check("rst_frame_cnt", 32'(frame_cnt[0]), 0);
        check("rst_drop_cnt", 32'(drop_cnt[0]), 0);
        send_frame(0, MAC, ETYPE, 5, 8'h80, 1'b0, 0, 1'b1);
        idle(0, 1);
        read_n(0, 5);
        idle(0, 2);
        check("post_rst_frame_cnt", 32'(frame_cnt[0]), 1);
        check("post_rst_drop_cnt", 32'(drop_cnt[0]), 0);
        check("post_rst_queue_empty", 32'(exp_q0.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
